// File: rtl/dmem_responder.sv
// dmem_responder
// Handshaked data-memory responder for the multi-cycle RV64 core. It accepts
// one load/store request, waits WAIT_CYCLES cycles, performs the access and
// returns the (extended) load data plus an error flag. Loads and stores follow
// the RISC-V funct3 width and sign rules.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset (memory contents are kept)
//   req_valid  request present            req_ready  responder is idle
//   req_we     1 = store, 0 = load        req_addr   byte address
//   req_size   funct3 of the access       req_wdata  store data
//   rsp_valid  response present           rsp_ready  core takes the response
//   rsp_rdata  extended load data         rsp_err    request failed, no write
//
// Build option: define DMEM_ALIGN_CHECK_EN to reject misaligned accesses with
// rsp_err. Without it the low address bits are truncated to the access size.

module dmem_responder #(
  parameter int DEPTH_WORDS = 512,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;

  logic        we_reg;
  logic [63:0] addr_reg;
  logic [2:0]  size_reg;
  logic [63:0] wdata_reg;
  logic [63:0] rd_word_reg;
  logic [63:0] rsp_rdata_reg;
  logic        rsp_err_reg;

  logic [63:0] mem [DEPTH_WORDS];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_next = S_ACCESS;
          end else begin
            state_next = S_WAIT;
            cnt_next   = 4'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg <= 4'd1) begin
          state_next = S_ACCESS;
          cnt_next   = 4'd0;
        end
      end
      S_ACCESS: state_next = S_RESP;
      S_RESP: begin
        if (rsp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign req_ready = (state_reg == S_IDLE);
  assign rsp_valid = (state_reg == S_RESP);
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

  // ------------------------------------------------------ access decode
  logic [1:0]    width;
  logic [2:0]    off_raw, off;
  logic          misaligned, out_of_range, bad_size, access_err;
  logic [AW-1:0] idx, rd_idx;
  logic [63:0]   shifted, load_val, wdata_shift, merged;
  logic [7:0]    byte_en;

  assign width   = size_reg[1:0];
  assign off_raw = addr_reg[2:0];
  assign idx     = addr_reg[3 +: AW];

  always_comb begin
    misaligned = 1'b0;
    off        = off_raw;
    byte_en    = 8'h01;
    case (width)
      2'd0: begin off = off_raw;                misaligned = 1'b0;             byte_en = 8'h01; end
      2'd1: begin off = {off_raw[2:1], 1'b0};   misaligned = off_raw[0];       byte_en = 8'h03; end
      2'd2: begin off = {off_raw[2], 2'b00};    misaligned = |off_raw[1:0];    byte_en = 8'h0F; end
      default: begin off = 3'd0;                misaligned = |off_raw;         byte_en = 8'hFF; end
    endcase
    byte_en = byte_en << off;
  end

  assign out_of_range = |addr_reg[63:3+AW];
  // Loads reject only funct3 7; stores only have SB/SH/SW/SD (0..3).
  assign bad_size     = we_reg ? size_reg[2] : (size_reg == 3'd7);

`ifdef DMEM_ALIGN_CHECK_EN
  assign access_err = out_of_range | bad_size | misaligned;
`else
  assign access_err = out_of_range | bad_size;
`endif

  assign shifted     = rd_word_reg >> {off, 3'b000};
  assign wdata_shift = wdata_reg << {off, 3'b000};

  always_comb begin
    load_val = 64'd0;
    case (width)
      2'd0: load_val = size_reg[2] ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      2'd1: load_val = size_reg[2] ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'd2: load_val = size_reg[2] ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: load_val = shifted;
    endcase
  end

  // Read-modify-write merge: only the enabled byte lanes take store data.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_merge
      assign merged[gi*8 +: 8] = byte_en[gi] ? wdata_shift[gi*8 +: 8] : rd_word_reg[gi*8 +: 8];
    end
  endgenerate

  // ----------------------------------------------------------- memory
  // While idle the read port follows the incoming address so the word is
  // already registered when ACCESS is reached, even with zero wait states.
  assign rd_idx = (state_reg == S_IDLE) ? req_addr[3 +: AW] : idx;

  always_ff @(posedge clk) begin
    rd_word_reg <= mem[rd_idx];
    if (!rst && state_reg == S_ACCESS && we_reg && !access_err)
      mem[idx] <= merged;
  end

  // ------------------------------------------------ request / response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_reg        <= 1'b0;
      addr_reg      <= 64'd0;
      size_reg      <= 3'd0;
      wdata_reg     <= 64'd0;
      rsp_rdata_reg <= 64'd0;
      rsp_err_reg   <= 1'b0;
    end else begin
      if (state_reg == S_IDLE && req_valid) begin
        we_reg    <= req_we;
        addr_reg  <= req_addr;
        size_reg  <= req_size;
        wdata_reg <= req_wdata;
      end
      if (state_reg == S_ACCESS) begin
        rsp_err_reg   <= access_err;
        rsp_rdata_reg <= (access_err || we_reg) ? 64'd0 : load_val;
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Handshaked data-memory responder for the multi-cycle RV64 core; it is the target end of the core's load/store port.
- Accepts one load or store request, waits a programmable number of cycles, then performs the access.
- Applies RISC-V width and sign rules from funct3 and returns read data plus an error flag through a response handshake.
- Replaces the bare datamem, so the core's fetch/execute sequencing can tolerate variable memory latency.

Parameters:
- DEPTH_WORDS, 512, number of 64-bit memory words; must be a power of 2.
- WAIT_CYCLES, 2, extra wait states inserted between request accept and memory access; range 0..15.

Ports:
- clk  input  1  rising-edge clock, the single clock of the block
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  64  byte address (ALU result)
- req_size  input  3  funct3 of the load/store
- req_wdata  input  64  store data (rs2 value)
- rsp_valid  output  1  response present
- rsp_ready  input  1  core accepts the response
- rsp_rdata  output  64  load result, already extended
- rsp_err  output  1  request failed, nothing was written

Behaviour:
- Reset: asserting rst forces these outputs immediately:
  - state = IDLE
  - req_ready = 1
  - rsp_valid = 0
  - rsp_rdata = 0
  - rsp_err = 0
  - wait counter = 0
- rst does not clear the memory array. Simulation initialises it to zero.
- FSM states are IDLE, WAIT, ACCESS, RESP. req_ready = 1 only in IDLE.
- IDLE:
  - A request is accepted on the edge where req_valid && req_ready.
  - On accept, latch we, addr, size and wdata; later changes on the req_* inputs are ignored.
  - Next state is WAIT with counter = WAIT_CYCLES, or ACCESS if WAIT_CYCLES == 0.
- WAIT: the counter decrements on each edge. The edge where the counter equals 1 moves to ACCESS.
- ACCESS: one cycle. On its closing edge the access is evaluated and the state moves to RESP.
- Word index = addr[3 +: log2(DEPTH_WORDS)]. Byte offset = addr[2:0].
- Error conditions; any one of these gives rsp_err = 1 and rsp_rdata = 0, with no memory write:
  - addr >> 3 >= DEPTH_WORDS (out of range)
  - load with size 7
  - store with size 4..7
  - misaligned access (see Optional Feature)
- Loads, keyed on size:
  - 0 = LB, 1 = LH, 2 = LW, 3 = LD: sign-extend to 64 bits.
  - 4 = LBU, 5 = LHU, 6 = LWU: zero-extend to 64 bits.
  - The field is taken from the word at the byte offset.
- Stores, keyed on size:
  - 0 = SB, 1 = SH, 2 = SW, 3 = SD.
  - Read-modify-write merges only the addressed bytes, taken from the low bits of wdata; the other bytes of the word are unchanged.
  - rsp_rdata = 0.
- RESP:
  - rsp_valid = 1, and rsp_rdata and rsp_err hold stable until rsp_ready.
  - The edge with rsp_valid && rsp_ready moves to IDLE and clears rsp_valid.
  - A new request cannot be accepted on that same edge; req_ready rises in the following cycle.
- Latency: rsp_valid is first high after the (WAIT_CYCLES+1)th rising edge following the accepting edge. rsp_ready held high gives a 1-cycle response.
- Reset mid-operation: returns to IDLE at once. A store that has not completed its ACCESS edge is discarded, and no response is issued.
- Memory is single-port. Only one transaction is ever outstanding, so there is no read/write hazard.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined: an address not aligned to its access size (half: addr[0] != 0; word: addr[1:0] != 0; double: addr[2:0] != 0) returns rsp_err = 1, with no write and rdata 0.
- Undefined: the low address bits are forced to the access alignment (the offset is truncated down). The access proceeds without error.

Test Plan:
- SD addr 0x10 wdata 0x8877665544332211, then LD 0x10 -> rsp_rdata 0x8877665544332211, rsp_err 0; with WAIT_CYCLES=2, rsp_valid rises 3 edges after each accept.
- After the SD above, LB 0x17 -> 0xFFFFFFFFFFFFFF88; LBU 0x17 -> 0x0000000000000088; LW 0x14 -> 0xFFFFFFFF88776655; LHU 0x12 -> 0x0000000000004433.
- SB addr 0x11 wdata 0xAB, then LD 0x10 -> 0x887766554433AB11; the neighbouring bytes are unchanged.
- Load at addr 8*DEPTH_WORDS (0x1000 at the default) -> rsp_err 1, rdata 0. Store size 5 -> rsp_err 1, and a following LD shows memory unchanged.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rdata and err stay stable and req_ready stays 0. Raise rsp_ready -> IDLE, req_ready=1 next cycle. Assert rst during WAIT of an SD to 0x20 -> outputs cleared at once, and LD 0x20 afterwards returns the old value.
- LW addr 0x12: with DMEM_ALIGN_CHECK_EN -> rsp_err 1; without it -> data of LW 0x10 and rsp_err 0.
